// File: rtl/mips32_prog_loader_if.sv
// Word-stream handshake that feeds load records into mips32_prog_loader.
interface mips32_prog_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mips32_prog_loader.sv
// Stream-driven program/data loader for pipe_mips32: LOAD records fill memory, START releases the core.
// Defining LOADER_CHECKSUM_EN adds a trailing wrap-around sum word to every non-empty LOAD record.
module mips32_prog_loader #(
   parameter int         MEM_AW = 10,
   parameter logic [7:0] MAGIC  = 8'hA5
) (
   input  logic                clk1,
   input  logic                reset,
   mips32_prog_loader_if.slave in_stream,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   output logic                cpu_hold,
   output logic                cpu_start,
   output logic [MEM_AW-1:0]   start_pc,
   output logic                busy,
   output logic                error,
   output logic [15:0]         words_loaded
);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, RUN, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, ADDR, DATA, RUN, ERROR} state_t;
`endif

   state_t            state;
   state_t            state_next;
   logic              ready;
   logic              accept;
   logic              mem_we_q;
   logic [MEM_AW-1:0] remaining;
   logic [MEM_AW-1:0] next_addr;
   logic [7:0]        hdr_magic;
   logic [7:0]        hdr_type;
   logic [MEM_AW-1:0] hdr_low;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum;
`endif

   assign hdr_magic = in_stream.in_data[31:24];
   assign hdr_type  = in_stream.in_data[23:16];
   assign hdr_low   = in_stream.in_data[MEM_AW-1:0];

   always_ff @(posedge clk1) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Ready is forced low while reset is asserted so nothing is accepted in the reset cycle.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         IDLE, ADDR, DATA: ready = !reset;
`ifdef LOADER_CHECKSUM_EN
         CSUM:             ready = !reset;
`endif
         default:          ready = 1'b0;
      endcase
      accept = in_stream.in_valid && ready;
      if (accept) begin
         case (state)
            IDLE: begin
               if (hdr_magic != MAGIC)     state_next = ERROR;
               else if (hdr_type == 8'h01) state_next = ADDR;
               else if (hdr_type == 8'h02) state_next = RUN;
               else                        state_next = ERROR;
            end
            ADDR: state_next = (remaining == '0) ? IDLE : DATA;
            DATA: begin
               if (remaining == MEM_AW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  state_next = CSUM;
`else
                  state_next = IDLE;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: state_next = (in_stream.in_data == sum) ? IDLE : ERROR;
`endif
            default: state_next = state;
         endcase
      end
   end

   assign in_stream.in_ready = ready;

   // Writes are registered one cycle after the data word is accepted; next_addr wraps naturally.
   always_ff @(posedge clk1) begin
      if (reset) begin
         remaining    <= '0;
         next_addr    <= '0;
         mem_we_q     <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_hold     <= 1'b1;
         cpu_start    <= 1'b0;
         start_pc     <= '0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum          <= '0;
`endif
      end else begin
         mem_we_q  <= 1'b0;
         cpu_start <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  remaining <= hdr_low;
                  if (state_next == RUN) begin
                     start_pc  <= hdr_low;
                     cpu_start <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end
               end
               ADDR: begin
                  next_addr <= hdr_low;
`ifdef LOADER_CHECKSUM_EN
                  sum       <= '0;
`endif
               end
               DATA: begin
                  mem_we_q  <= 1'b1;
                  mem_addr  <= next_addr;
                  mem_wdata <= in_stream.in_data;
                  next_addr <= next_addr + MEM_AW'(1);
                  remaining <= remaining - MEM_AW'(1);
`ifdef LOADER_CHECKSUM_EN
                  sum       <= sum + in_stream.in_data;
`endif
                  if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
               end
               default: remaining <= remaining;
            endcase
         end
      end
   end

   // A write still pending when reset arrives is squashed so the core never sees it.
   assign mem_we = mem_we_q && !reset;

`ifdef LOADER_CHECKSUM_EN
   assign busy  = (state == ADDR) || (state == DATA) || (state == CSUM);
`else
   assign busy  = (state == ADDR) || (state == DATA);
`endif
   assign error = (state == ERROR);
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed self-checking bench for mips32_prog_loader: load, wrap, back-pressure, start, errors, reset.
module tb_mips32_prog_loader;
   localparam int MEM_AW = 10;

   logic              clk1 = 1'b0;
   logic              reset;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              cpu_start;
   logic [MEM_AW-1:0] start_pc;
   logic              busy;
   logic              error;
   logic [15:0]       words_loaded;

   int errors   = 0;
   int checks   = 0;
   int wr_count = 0;
   int wr_before;

   logic [31:0] prog     [8];
   logic [31:0] wrapData [4];
   int          wrapAddr [4];
   logic [31:0] sum;

   mips32_prog_loader_if stream ();

   mips32_prog_loader #(.MEM_AW(MEM_AW), .MAGIC(8'hA5)) dut (
      .clk1         (clk1),
      .reset        (reset),
      .in_stream    (stream),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .cpu_start    (cpu_start),
      .start_pc     (start_pc),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk1 = ~clk1;

   // Counts memory writes as the core would see them, mid-cycle.
   always @(negedge clk1) if (mem_we === 1'b1) wr_count++;

   task automatic applyStimulus(input logic v, input logic [31:0] d);
      stream.in_valid = v;
      stream.in_data  = d;
      @(posedge clk1);
      #1;
      stream.in_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, stream.in_ready, 0);
      checkOutput({tag, "_mem_we"}, mem_we, 0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
      checkOutput({tag, "_cpu_start"}, cpu_start, 0);
      checkOutput({tag, "_start_pc"}, start_pc, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_error"}, error, 0);
      checkOutput({tag, "_words"}, words_loaded, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      stream.in_valid = 1'b0;
      @(posedge clk1);
      #1;
      checkResetValues("rst");
      reset = 1'b0;
      #1;
      checkOutput("rst_release_ready", stream.in_ready, 1);
   endtask

   task automatic checkWrite(input string tag, input int addr, input logic [31:0] data);
      checkOutput({tag, "_we"}, mem_we, 1);
      checkOutput({tag, "_addr"}, mem_addr, 32'(addr));
      checkOutput({tag, "_data"}, mem_wdata, data);
   endtask

   initial begin
      prog     = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                   32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
      wrapData = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      wrapAddr = '{1022, 1023, 0, 1};
      stream.in_valid = 1'b0;
      stream.in_data  = 32'h0;
      reset = 1'b1;
      $display("[TB] starting mips32_prog_loader directed sequence");
      doReset();

      // Program load: 8 words at 0..7 on consecutive cycles.
      applyStimulus(1'b1, 32'hA5010008);
      checkOutput("prog_hdr_busy", busy, 1);
      checkOutput("prog_hdr_we", mem_we, 0);
      applyStimulus(1'b1, 32'h00000000);
      checkOutput("prog_addr_we", mem_we, 0);
      sum = 32'h0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, prog[i]);
         checkWrite("prog", i, prog[i]);
         sum = sum + prog[i];
      end
      checkOutput("prog_words", words_loaded, 8);
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(1'b1, sum);
`endif
      applyStimulus(1'b0, 32'h0);
      checkOutput("prog_idle_busy", busy, 0);
      checkOutput("prog_idle_we", mem_we, 0);

      // Single data word 85 to address 120.
      applyStimulus(1'b1, 32'hA5010001);
      applyStimulus(1'b1, 32'd120);
      applyStimulus(1'b1, 32'd85);
      checkWrite("data", 120, 32'd85);
      checkOutput("data_words", words_loaded, 9);
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(1'b1, 32'd85);
`endif

      // Address wrap with a valid gap after every word.
      applyStimulus(1'b1, 32'hA5010004);
      applyStimulus(1'b1, 32'h000003FE);
      sum = 32'h0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, wrapData[i]);
         checkWrite("wrap", wrapAddr[i], wrapData[i]);
         sum = sum + wrapData[i];
         applyStimulus(1'b0, 32'hDEADBEEF);
         checkOutput("wrap_gap_we", mem_we, 0);
         checkOutput("wrap_gap_words", words_loaded, 32'(10 + i));
      end
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(1'b1, sum);
`endif
      applyStimulus(1'b0, 32'h0);
      checkOutput("pre_start_hold", cpu_hold, 1);

      // START at pc 0, then RUN ignores further input.
      applyStimulus(1'b1, 32'hA5020000);
      checkOutput("start_pulse", cpu_start, 1);
      checkOutput("start_hold", cpu_hold, 0);
      checkOutput("start_pc", start_pc, 0);
      checkOutput("start_ready", stream.in_ready, 0);
      applyStimulus(1'b1, 32'hA5010001);
      checkOutput("run_pulse_end", cpu_start, 0);
      checkOutput("run_hold", cpu_hold, 0);
      checkOutput("run_we", mem_we, 0);
      checkOutput("run_busy", busy, 0);
      checkOutput("run_words", words_loaded, 13);

      // Bad magic: sticky error, no writes, core stays held.
      doReset();
      wr_before = wr_count;
      applyStimulus(1'b1, 32'h5A010003);
      checkOutput("badmagic_error", error, 1);
      checkOutput("badmagic_ready", stream.in_ready, 0);
      checkOutput("badmagic_hold", cpu_hold, 1);
      applyStimulus(1'b1, 32'h00000000);
      applyStimulus(1'b1, 32'h00000011);
      applyStimulus(1'b1, 32'h00000022);
      applyStimulus(1'b0, 32'h0);
      checkOutput("badmagic_sticky", error, 1);
      checkOutput("badmagic_ready2", stream.in_ready, 0);
      checkOutput("badmagic_writes", 32'(wr_count - wr_before), 0);
      checkOutput("badmagic_words", words_loaded, 0);

      // Unknown record type is also an error.
      doReset();
      applyStimulus(1'b1, 32'hA5030000);
      checkOutput("badtype_error", error, 1);
      checkOutput("badtype_busy", busy, 0);

      // Reset the cycle after the 2nd of 4 data words: only the first write lands.
      doReset();
      wr_before = wr_count;
      applyStimulus(1'b1, 32'hA5010004);
      applyStimulus(1'b1, 32'h00000200);
      applyStimulus(1'b1, 32'hCAFE0001);
      checkWrite("midrst_first", 32'h200, 32'hCAFE0001);
      applyStimulus(1'b1, 32'hCAFE0002);
      reset = 1'b1;
      #1;
      checkOutput("midrst_squash", mem_we, 0);
      @(posedge clk1);
      #1;
      checkResetValues("midrst");
      checkOutput("midrst_writes", 32'(wr_count - wr_before), 1);
      reset = 1'b0;
      applyStimulus(1'b1, 32'hA5010002);
      applyStimulus(1'b1, 32'h00000005);
      applyStimulus(1'b1, 32'd77);
      checkWrite("after_rst0", 5, 32'd77);
      applyStimulus(1'b1, 32'd88);
      checkWrite("after_rst1", 6, 32'd88);
      checkOutput("after_rst_words", words_loaded, 2);
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(1'b1, 32'd165);
      checkOutput("after_rst_csum_err", error, 0);

      // Checksum good then bad; writes stand either way.
      doReset();
      wr_before = wr_count;
      applyStimulus(1'b1, 32'hA5010002);
      applyStimulus(1'b1, 32'h00000040);
      applyStimulus(1'b1, 32'd1);
      applyStimulus(1'b1, 32'd2);
      applyStimulus(1'b1, 32'd3);
      checkOutput("csum_ok_error", error, 0);
      checkOutput("csum_ok_ready", stream.in_ready, 1);
      applyStimulus(1'b1, 32'hA5010002);
      applyStimulus(1'b1, 32'h00000040);
      applyStimulus(1'b1, 32'd1);
      applyStimulus(1'b1, 32'd2);
      applyStimulus(1'b1, 32'd4);
      checkOutput("csum_bad_error", error, 1);
      applyStimulus(1'b0, 32'h0);
      checkOutput("csum_writes", 32'(wr_count - wr_before), 4);
`endif

      // START at a nonzero pc.
      doReset();
      applyStimulus(1'b1, 32'hA5020155);
      checkOutput("start2_pc", start_pc, 32'h155);
      checkOutput("start2_pulse", cpu_start, 1);
      checkOutput("start2_hold", cpu_hold, 0);
      applyStimulus(1'b0, 32'h0);
      checkOutput("start2_pulse_end", cpu_start, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Stream-driven program/data loader for the `pipe_mips32` core. It accepts a 32-bit word stream of load records and writes them into the core's unified 1024-word memory through a write port, holding the core halted throughout. A start record then releases the core at a chosen PC. It sits directly upstream of the core and replaces direct hierarchical preloading of `Mem`, `PC` and `HALTED`.

## Interface
- `MEM_AW`, 10: memory word-address width; addresses wrap modulo 2^MEM_AW.
- `MAGIC`, 8'hA5: required value in header bits [31:24].
- `clk1`  in  1  clock; the loader runs on the core's clk1 phase only.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader accepts the word this cycle; transfer occurs when `in_valid && in_ready`.
- `in_data`  in  32  input word.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  MEM_AW  memory write address.
- `mem_wdata`  out  32  memory write data.
- `cpu_hold`  out  1  keeps the core halted (drives HALTED).
- `cpu_start`  out  1  one-cycle pulse; the core loads `start_pc` and clears TAKEN_BRANCH.
- `start_pc`  out  MEM_AW  initial PC.
- `busy`  out  1  a record is in progress (state not IDLE/RUN/ERROR).
- `error`  out  1  sticky protocol error.
- `words_loaded`  out  16  count of data words written since reset; saturates at 16'hFFFF.

## Operation
- Header word: [31:24] = MAGIC; [23:16] type; [MEM_AW-1:0] count or PC. Type 8'h01 is a LOAD record. Type 8'h02 is a START record. Any other type, or a wrong magic value, is an error.
- LOAD record: header, then an address word (bits [MEM_AW-1:0] = base address), then `count` data words. Data word i is written to `(base+i) mod 2^MEM_AW`. A count of 0 returns to IDLE after the address word with no writes.
- START record: `start_pc` latches the header's [MEM_AW-1:0]. `cpu_start` pulses and `cpu_hold` drops. The loader enters RUN, which is terminal until reset.
- States and transitions:
  - IDLE → ADDR on a LOAD header.
  - IDLE → RUN on a START header.
  - IDLE → ERROR on a bad header.
  - ADDR → DATA (count > 0) or IDLE (count = 0).
  - DATA → IDLE after the last word, or → CSUM when checksum is enabled.
  - CSUM → IDLE if the checksum matches, → ERROR if it does not.
- `in_ready` = 1 in IDLE/ADDR/DATA/CSUM. It is 0 in RUN and ERROR, and 0 during the reset cycle.
- ERROR: `error` = 1 and the loader accepts nothing further; exit is by reset only. `cpu_hold` stays 1. Writes already issued stand.
- Back-pressure: `in_valid` gaps stall the FSM in place, with no write and no count change.

## Timing
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `cpu_start` 0, `start_pc` 0, `busy` 0, `error` 0, `words_loaded` 0. The state after reset is IDLE.
- Write latency is 1 cycle: a data word accepted in cycle N gives `mem_we` = 1 with the registered addr/data in cycle N+1. Back-to-back words give back-to-back writes.
- `words_loaded` increments in the same cycle as `mem_we`.
- START accepted in cycle N gives `cpu_start` = 1 and `cpu_hold` = 0 in cycle N+1, with `start_pc` valid by cycle N+1. `cpu_start` is 0 from cycle N+2.
- `error` rises in the cycle after the offending word is accepted.
- Reset mid-record abandons the record. A write pending for the cycle after reset is squashed (`mem_we` = 0). `cpu_hold` returns to 1.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Each LOAD record with count > 0 carries one extra trailing word in state CSUM.
  - That word must equal the 32-bit wrap-around sum of the record's data words.
  - On mismatch the loader sets `error` and enters ERROR. The data writes still occur.
- `LOADER_CHECKSUM_EN` undefined: there is no CSUM state, and DATA returns directly to IDLE.

## Test plan
- Program load: send LOAD count 8, base 0, with 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000.
  - Expect 8 writes to addresses 0–7 on consecutive cycles and `words_loaded` = 8.
- Data + start:
  - Send LOAD count 1, base 120, data 85. Expect a write of 85 to address 120.
  - Then send START with pc 0. Expect one `cpu_start` pulse and `cpu_hold` 1→0. With the core attached, Mem[121] = 130 after run.
- Wrap and back-pressure:
  - Send LOAD count 4, base 1022, with `in_valid` deasserted every other cycle.
  - Expect writes to 1022, 1023, 0, 1 and no writes during gaps.
- Bad header: send header 5A010003.
  - Expect `error` = 1 next cycle, `in_ready` = 0 permanently, no writes, and `cpu_hold` = 1.
- Reset mid-record:
  - Assert `reset` the cycle after the 2nd of 4 data words.
  - Expect only 1 write to complete, all outputs at reset values, and a subsequent new LOAD to work.
- Checksum (`LOADER_CHECKSUM_EN`):
  - Words 1, 2 with checksum 3 → return to IDLE, `error` 0.
  - Same words with checksum 4 → `error` = 1, but both writes present.
